// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, MemSize encoding
// and the fetch-timeout NOP instruction.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

    // MemSize encoding shared with the decoder
    localparam logic MEM_SIZE_BYTE = 1'b0;
    localparam logic MEM_SIZE_WORD = 1'b1;

    localparam logic [3:0]  SEL_WORD = 4'b1111;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch requester, data requester and downstream memory port
// of the arbiter. slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    // instruction fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    // data requester
    logic              dm_req;
    logic              dm_we;
    logic              dm_size;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_ack;
    logic              dm_err;
    logic [31:0]       dm_rdata;
    // shared memory port
    logic              bus_stb;
    logic              bus_we;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        output dm_ack, dm_err, dm_rdata,
        output bus_stb, bus_we, bus_sel, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
        input  dm_ack, dm_err, dm_rdata,
        input  bus_stb, bus_we, bus_sel, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_lane.sv
// Byte-lane steering for data accesses: byte select, write-data
// replication, misalignment detection and byte-load sign extension.
module mem_lane
    import mem_arbiter_pkg::*;
(
    input  logic        req_size,
    input  logic [1:0]  req_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic        misaligned,
    input  logic        rd_size,
    input  logic [1:0]  rd_lo,
    input  logic [31:0] bus_rdata,
    output logic [31:0] rdata
);

    logic [7:0] rd_byte;

    // request side: lane enables and write data for the current access
    always_comb begin
        if (req_size == MEM_SIZE_WORD) begin
            sel        = SEL_WORD;
            wdata      = req_wdata;
            misaligned = (req_lo != 2'b00);
        end else begin
            sel        = 4'b0001 << req_lo;
            wdata      = {4{req_wdata[7:0]}};
            misaligned = 1'b0;
        end
    end

    // response side: pick the addressed lane and sign-extend byte loads
    always_comb begin
        rd_byte = bus_rdata[{rd_lo, 3'b000} +: 8];
        if (rd_size == MEM_SIZE_WORD) begin
            rdata = bus_rdata;
        end else begin
            rdata = {{24{rd_byte[7]}}, rd_byte};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch + data) onto a single memory port.
// Optional bus-ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave mif
);

    arb_state_t        state_q, state_n;
    logic              stb_q, stb_n, we_q, we_n;
    logic [3:0]        sel_q, sel_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [31:0]       wdata_q, wdata_n;
    logic              if_ack_q, if_ack_n, dm_ack_q, dm_ack_n, dm_err_q, dm_err_n;
    logic [31:0]       if_rdata_q, if_rdata_n, dm_rdata_q, dm_rdata_n;
    logic [1:0]        streak_q, streak_n;
    logic              rd_size_q, rd_size_n, bad_q, bad_n;
    logic [1:0]        rd_lo_q, rd_lo_n;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_wdata, lane_rdata;
    logic              lane_misaligned;
    logic              grant_dm;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [31:0]       tmo_q, tmo_n;
    logic              tmo_hit;
    assign tmo_hit = (tmo_q == TIMEOUT_CYCLES - 1);
`endif

    mem_lane u_lane (
        .req_size   (mif.dm_size),
        .req_lo     (mif.dm_addr[1:0]),
        .req_wdata  (mif.dm_wdata),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .misaligned (lane_misaligned),
        .rd_size    (rd_size_q),
        .rd_lo      (rd_lo_q),
        .bus_rdata  (mif.bus_rdata),
        .rdata      (lane_rdata)
    );

    // dm wins ties unless it already took two grants in a row over a waiting fetch
    assign grant_dm = mif.dm_req && !(mif.if_req && streak_q == 2'd2);

    // next-state, bus fields and requester responses
    always_comb begin
        state_n    = state_q;
        stb_n      = stb_q;
        we_n       = we_q;
        sel_n      = sel_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        if_ack_n   = 1'b0;
        if_rdata_n = if_rdata_q;
        dm_ack_n   = 1'b0;
        dm_err_n   = 1'b0;
        dm_rdata_n = dm_rdata_q;
        streak_n   = streak_q;
        rd_size_n  = rd_size_q;
        rd_lo_n    = rd_lo_q;
        bad_n      = bad_q;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_n      = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    state_n   = DM_BUSY;
                    streak_n  = mif.if_req ? streak_q + 2'd1 : streak_q;
                    we_n      = mif.dm_we;
                    sel_n     = lane_sel;
                    wdata_n   = lane_wdata;
                    addr_n    = {mif.dm_addr[ADDR_W-1:2], 2'b00};
                    rd_size_n = mif.dm_size;
                    rd_lo_n   = mif.dm_addr[1:0];
                    // misaligned word: sit one cycle in DM_BUSY without a strobe, then error
                    bad_n     = lane_misaligned;
                    stb_n     = !lane_misaligned;
                end else if (mif.if_req) begin
                    state_n  = IF_BUSY;
                    streak_n = '0;
                    stb_n    = 1'b1;
                    we_n     = 1'b0;
                    sel_n    = SEL_WORD;
                    wdata_n  = '0;
                    addr_n   = {mif.if_addr[ADDR_W-1:2], 2'b00};
                end
            end
            IF_BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
                tmo_n = tmo_q + 32'd1;
`endif
                if (mif.bus_ack) begin
                    state_n    = IDLE;
                    stb_n      = 1'b0;
                    if_ack_n   = 1'b1;
                    if_rdata_n = mif.bus_rdata;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n    = IDLE;
                    stb_n      = 1'b0;
                    if_ack_n   = 1'b1;
                    if_rdata_n = NOP_INSN;
                end
`endif
            end
            DM_BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
                tmo_n = tmo_q + 32'd1;
`endif
                if (bad_q) begin
                    state_n    = IDLE;
                    bad_n      = 1'b0;
                    dm_ack_n   = 1'b1;
                    dm_err_n   = 1'b1;
                    dm_rdata_n = '0;
                end else if (mif.bus_ack) begin
                    state_n    = IDLE;
                    stb_n      = 1'b0;
                    dm_ack_n   = 1'b1;
                    dm_rdata_n = lane_rdata;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n    = IDLE;
                    stb_n      = 1'b0;
                    dm_ack_n   = 1'b1;
                    dm_err_n   = 1'b1;
                    dm_rdata_n = '0;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_ack_q   <= 1'b0;
            dm_err_q   <= 1'b0;
            dm_rdata_q <= '0;
            streak_q   <= '0;
            rd_size_q  <= 1'b0;
            rd_lo_q    <= '0;
            bad_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_n;
            stb_q      <= stb_n;
            we_q       <= we_n;
            sel_q      <= sel_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            if_ack_q   <= if_ack_n;
            if_rdata_q <= if_rdata_n;
            dm_ack_q   <= dm_ack_n;
            dm_err_q   <= dm_err_n;
            dm_rdata_q <= dm_rdata_n;
            streak_q   <= streak_n;
            rd_size_q  <= rd_size_n;
            rd_lo_q    <= rd_lo_n;
            bad_q      <= bad_n;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= tmo_n;
`endif
        end
    end

    assign mif.bus_stb   = stb_q;
    assign mif.bus_we    = we_q;
    assign mif.bus_sel   = sel_q;
    assign mif.bus_addr  = addr_q;
    assign mif.bus_wdata = wdata_q;
    assign mif.if_ack    = if_ack_q;
    assign mif.if_rdata  = if_rdata_q;
    assign mif.dm_ack    = dm_ack_q;
    assign mif.dm_err    = dm_err_q;
    assign mif.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Requesters drop req in the cycle they
// see ack; a req still high at that point is taken as the next request.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) mif();

    mem_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    int vectors = 0;
    int errors  = 0;

    // memory responder controls
    logic        resp_en    = 1'b0;
    int          resp_delay = 0;
    logic [31:0] resp_data  = '0;
    logic        force_ack  = 1'b0;
    int          wait_cnt   = 0;

    // memory model: acks a strobe after resp_delay cycles, or on demand
    always @(negedge clk) begin
        #1;
        if (force_ack) begin
            mif.bus_ack   = 1'b1;
            mif.bus_rdata = resp_data;
        end else if (resp_en && mif.bus_stb === 1'b1 && mif.bus_ack !== 1'b1) begin
            if (wait_cnt >= resp_delay) begin
                mif.bus_ack   = 1'b1;
                mif.bus_rdata = resp_data;
                wait_cnt      = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            mif.bus_ack = 1'b0;
            if (mif.bus_stb !== 1'b1) wait_cnt = 0;
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mif.bus_stb, mif.bus_we, mif.if_ack, mif.dm_ack, mif.dm_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000",
                {mif.bus_stb, mif.bus_we, mif.if_ack, mif.dm_ack, mif.dm_err});
        end
        vectors++;
        if (mif.bus_sel !== 4'b0 || mif.bus_addr !== 32'h0 || mif.bus_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus: sel %h addr %h wdata %h want all 0",
                mif.bus_sel, mif.bus_addr, mif.bus_wdata);
        end
        vectors++;
        if (mif.if_rdata !== 32'h0 || mif.dm_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: if %h dm %h want 0", mif.if_rdata, mif.dm_rdata);
        end
        vectors++;
        if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int n;
        resp_en = 1'b1; resp_delay = 2; resp_data = 32'hDEAD_BEEF;
        mif.if_addr = 32'h100; mif.if_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (mif.bus_stb !== 1'b1 || mif.bus_addr !== 32'h100 || mif.bus_sel !== 4'b1111 || mif.bus_we !== 1'b0) begin
            errors++; $display("FAIL fetch_bus: stb %b addr %h sel %b we %b want 1 100 1111 0",
                mif.bus_stb, mif.bus_addr, mif.bus_sel, mif.bus_we);
        end
        n = 0;
        while (mif.if_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        mif.if_req = 1'b0;
        vectors++;
        if (n !== 3) begin
            errors++; $display("FAIL fetch_latency: got %0d cycles want 3", n);
        end
        vectors++;
        if (mif.if_rdata !== 32'hDEAD_BEEF || mif.bus_stb !== 1'b0 || mif.dm_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_ack: rdata %h stb %b dm_ack %b want deadbeef 0 0",
                mif.if_rdata, mif.bus_stb, mif.dm_ack);
        end
        @(negedge clk);
        vectors++;
        if (mif.if_ack !== 1'b0 || mif.if_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL fetch_pulse: ack %b rdata %h want 0 deadbeef", mif.if_ack, mif.if_rdata);
        end
    endtask

    task automatic test_dm_lanes();
        int n;
        // byte store at 0x203
        resp_en = 1'b1; resp_delay = 0; resp_data = 32'h0;
        mif.dm_we = 1'b1; mif.dm_size = 1'b0; mif.dm_addr = 32'h203;
        mif.dm_wdata = 32'h0000_00A5; mif.dm_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (mif.bus_sel !== 4'b1000 || mif.bus_wdata !== 32'hA5A5_A5A5 || mif.bus_addr !== 32'h200 || mif.bus_we !== 1'b1) begin
            errors++; $display("FAIL byte_store: sel %b wdata %h addr %h we %b want 1000 a5a5a5a5 200 1",
                mif.bus_sel, mif.bus_wdata, mif.bus_addr, mif.bus_we);
        end
        n = 0;
        while (mif.dm_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        mif.dm_req = 1'b0;
        vectors++;
        if (n !== 1 || mif.dm_err !== 1'b0) begin
            errors++; $display("FAIL byte_store_ack: latency %0d err %b want 1 0", n, mif.dm_err);
        end
        @(negedge clk);
        // byte load at 0x201
        resp_data = 32'h0000_8000;
        mif.dm_we = 1'b0; mif.dm_addr = 32'h201; mif.dm_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (mif.bus_sel !== 4'b0010 || mif.bus_addr !== 32'h200) begin
            errors++; $display("FAIL byte_load_sel: sel %b addr %h want 0010 200", mif.bus_sel, mif.bus_addr);
        end
        n = 0;
        while (mif.dm_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        mif.dm_req = 1'b0;
        vectors++;
        if (mif.dm_rdata !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL byte_load_rdata: got %h want ffffff80", mif.dm_rdata);
        end
        @(negedge clk);
        // word store at 0x44
        resp_data = 32'hCAFE_F00D;
        mif.dm_we = 1'b1; mif.dm_size = 1'b1; mif.dm_addr = 32'h44;
        mif.dm_wdata = 32'h1234_5678; mif.dm_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (mif.bus_sel !== 4'b1111 || mif.bus_wdata !== 32'h1234_5678 || mif.bus_addr !== 32'h44) begin
            errors++; $display("FAIL word_store: sel %b wdata %h addr %h want 1111 12345678 44",
                mif.bus_sel, mif.bus_wdata, mif.bus_addr);
        end
        n = 0;
        while (mif.dm_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        mif.dm_req = 1'b0;
        vectors++;
        if (mif.dm_rdata !== 32'hCAFE_F00D || n !== 1) begin
            errors++; $display("FAIL word_ack: rdata %h latency %0d want cafef00d 1", mif.dm_rdata, n);
        end
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        int ack_n = 0, err_n = 0, stb_n = 0, ack_at = -1;
        mif.dm_we = 1'b0; mif.dm_size = 1'b1; mif.dm_addr = 32'h102; mif.dm_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (mif.bus_stb === 1'b1) stb_n++;
            if (mif.dm_err === 1'b1) err_n++;
            if (mif.dm_ack === 1'b1) begin
                ack_n++;
                if (ack_at < 0) ack_at = i;
                mif.dm_req = 1'b0;
                vectors++;
                if (mif.dm_err !== 1'b1 || mif.dm_rdata !== 32'h0) begin
                    errors++; $display("FAIL misalign_resp: err %b rdata %h want 1 0", mif.dm_err, mif.dm_rdata);
                end
            end
        end
        mif.dm_req = 1'b0;
        vectors++;
        if (ack_n !== 1 || err_n !== 1 || stb_n !== 0 || ack_at !== 2) begin
            errors++; $display("FAIL misalign_count: ack %0d err %0d stb %0d at %0d want 1 1 0 2",
                ack_n, err_n, stb_n, ack_at);
        end
    endtask

    task automatic test_contention();
        logic [5:0] order = '0;
        int k = 0, both = 0, n = 0;
        resp_en = 1'b1; resp_delay = 0; resp_data = 32'h1111_2222;
        mif.if_addr = 32'h0; mif.dm_addr = 32'h80; mif.dm_we = 1'b0; mif.dm_size = 1'b1;
        mif.if_req = 1'b1; mif.dm_req = 1'b1;
        while (k < 6 && n < 60) begin
            @(negedge clk); n++;
            if (mif.if_ack === 1'b1 && mif.dm_ack === 1'b1) both++;
            if (mif.if_ack === 1'b1 || mif.dm_ack === 1'b1) begin
                order[k] = mif.if_ack;
                k++;
            end
        end
        mif.if_req = 1'b0; mif.dm_req = 1'b0;
        vectors++;
        if (k !== 6 || order !== 6'b100100) begin
            errors++; $display("FAIL contention_order: %0d grants order %b want 6 100100 (bit0 first, 1=if)", k, order);
        end
        vectors++;
        if (both !== 0) begin
            errors++; $display("FAIL contention_both_ack: got %0d cycles want 0", both);
        end
        @(negedge clk);
    endtask

    task automatic test_idle_ack();
        int bad = 0;
        resp_data = 32'h55AA_55AA;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mif.if_ack !== 1'b0 || mif.dm_ack !== 1'b0 || mif.bus_stb !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0 || mif.if_rdata !== 32'h1111_2222 || mif.dm_rdata !== 32'h1111_2222) begin
            errors++; $display("FAIL idle_ack: bad %0d if %h dm %h want 0 11112222 11112222",
                bad, mif.if_rdata, mif.dm_rdata);
        end
    endtask

    task automatic test_reset_busy();
        int bad = 0;
        resp_en = 1'b0; resp_data = 32'h7777_7777;
        mif.dm_we = 1'b0; mif.dm_size = 1'b1; mif.dm_addr = 32'h300; mif.dm_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (mif.bus_stb !== 1'b1 || dut.state_q !== DM_BUSY) begin
            errors++; $display("FAIL rst_busy_grant: stb %b state %0d want 1 %0d", mif.bus_stb, dut.state_q, DM_BUSY);
        end
        reset = 1'b0; mif.dm_req = 1'b0;
        @(negedge clk);
        reset = 1'b1; force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mif.dm_ack !== 1'b0 || mif.bus_stb !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0 || dut.state_q !== IDLE || mif.dm_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_busy: bad %0d state %0d rdata %h want 0 %0d 0", bad, dut.state_q, IDLE, mif.dm_rdata);
        end
        resp_en = 1'b1;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        resp_en = 1'b0;
        mif.if_addr = 32'h20; mif.if_req = 1'b1;
        @(negedge clk);
        while (mif.if_ack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        mif.if_req = 1'b0;
        vectors++;
        if (n !== 4 || mif.if_rdata !== NOP_INSN || mif.bus_stb !== 1'b0) begin
            errors++; $display("FAIL timeout_fetch: latency %0d rdata %h stb %b want 4 00000013 0",
                n, mif.if_rdata, mif.bus_stb);
        end
        resp_en = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        mif.if_req = 1'b0; mif.if_addr = '0;
        mif.dm_req = 1'b0; mif.dm_we = 1'b0; mif.dm_size = 1'b1;
        mif.dm_addr = '0; mif.dm_wdata = '0;
        test_reset();
        test_fetch();
        test_dm_lanes();
        test_misaligned();
        test_contention();
        test_idle_ack();
        test_reset_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
